// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTRE = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Ceiling log2 of a positive count; evaluated at elaboration time only.
  function automatic int clog2(input int n);
    int r;
    r = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 32'sd1;
      end
    end
    return r;
  endfunction

  // Width of a channel index; a single channel still gets a 1-bit index port.
  function automatic int ch_idx_w(input int n);
    return (n > 32'sd1) ? clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM counter: up-count (edge) or up/down-count (centre) against a
// period latched only at period boundaries, plus the boundary strobe.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] cnt,
  output logic             boundary,
  output logic             period_done
);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             bnd_s;

  // Last cycle of the current period (every cycle when the period is zero).
  always_comb begin
    bnd_s = 1'b0;
    if (!en) begin
      bnd_s = 1'b0;
    end else if (period_q == CNT_ZERO) begin
      bnd_s = 1'b1;
    end else if (mode_q == MODE_EDGE) begin
      bnd_s = (cnt_q == period_q);
    end else begin
      bnd_s = (cnt_q == CNT_ZERO) && (dir_q == DIR_DOWN);
    end
  end

  // Next counter/direction; period and mode are only re-sampled at a boundary
  // (or continuously while disabled so a fresh start uses current settings).
  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    period_d = period_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    if (!en) begin
      cnt_d    = CNT_ZERO;
      dir_d    = DIR_UP;
      period_d = period;
      mode_d   = mode;
    end else if (bnd_s) begin
      period_d = period;
      mode_d   = mode;
      done_d   = 1'b1;
      dir_d    = DIR_UP;
      // A centre period restarts at 1 so that count 0 appears once per period.
      if ((mode == MODE_CENTRE) && (period != CNT_ZERO)) begin
        cnt_d = CNT_ONE;
      end else begin
        cnt_d = CNT_ZERO;
      end
    end else if (mode_q == MODE_EDGE) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q == period_q) begin
        cnt_d = cnt_q - CNT_ONE;
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Timebase state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= CNT_ZERO;
      dir_q    <= DIR_UP;
      period_q <= CNT_ZERO;
      mode_q   <= MODE_EDGE;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
    end
  end

  assign cnt         = cnt_q;
  assign boundary    = bnd_s;
  assign period_done = done_q;

endmodule

// File: rtl/pwm_multi_ch.sv
// N-channel PWM generator: one shared timebase, per-channel shadow/active
// duty registers and a registered compare output.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int              N_CH     = 4,
  parameter int              CNT_W    = 8,
  parameter logic [N_CH-1:0] INV_MASK = '0,
  localparam int             CH_W     = ch_idx_w(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [CNT_W-1:0] period,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_duty,
  output logic [N_CH-1:0]  pwm_out,
  output logic             period_done
);

  logic [CNT_W-1:0] cnt_s;
  logic             bnd_s;
  logic             wr_ok_s;
  logic [N_CH-1:0]  raw_s;
  logic [N_CH-1:0]  pwm_q, pwm_d;

  pwm_timebase #(.CNT_W(CNT_W)) u_timebase (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .period     (period),
    .cnt        (cnt_s),
    .boundary   (bnd_s),
    .period_done(period_done)
  );

  // Out-of-range channel indices are dropped.
  assign wr_ok_s = wr_en && (int'(wr_ch) < N_CH);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] shd_q, shd_d;
    logic [CNT_W-1:0] act_q, act_d;

    // Shadow takes writes; active copies the pre-write shadow while idle or at a boundary.
    always_comb begin
      if (wr_ok_s && (wr_ch == CH_W'(i))) begin
        shd_d = wr_duty;
      end else begin
        shd_d = shd_q;
      end
      if (!en || bnd_s) begin
        act_d = shd_q;
      end else begin
        act_d = act_q;
      end
    end

    // Per-channel duty registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shd_q <= CNT_W'(1'b0);
        act_q <= CNT_W'(1'b0);
      end else begin
        shd_q <= shd_d;
        act_q <= act_d;
      end
    end

    assign raw_s[i] = (cnt_s < act_q);
  end

  // Output level: compare result while running, inactive level when disabled.
  always_comb begin
    if (en) begin
      pwm_d = raw_s ^ INV_MASK;
    end else begin
      pwm_d = INV_MASK;
    end
  end

  // Registered pad outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_q <= INV_MASK;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Self-checking bench for pwm_multi_ch: table-driven duty/period scenarios,
// directed corner sequences and random stimulus against a queue-based model.
module tb_pwm_multi_ch;

  localparam logic [3:0] INV1 = 4'b1010;

  logic       clk = 1'b0;
  logic       rst, en, mode, wr_en;
  logic [7:0] period, wr_duty;
  logic [1:0] wr_ch;
  logic [3:0] out0, out1;
  logic [2:0] out2;
  logic       done0, done1, done2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pwm_multi_ch #(.N_CH(4), .CNT_W(8), .INV_MASK(4'b0000)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .period(period), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_duty(wr_duty), .pwm_out(out0), .period_done(done0));

  pwm_multi_ch #(.N_CH(4), .CNT_W(8), .INV_MASK(INV1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .period(period), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_duty(wr_duty), .pwm_out(out1), .period_done(done1));

  // Three channels: channel index 3 is out of range for this instance.
  pwm_multi_ch #(.N_CH(3), .CNT_W(8), .INV_MASK(3'b000)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .period(period), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_duty(wr_duty), .pwm_out(out2), .period_done(done2));

  // ---------------- reference model ----------------
  // The current period is a queue of the count values it visits; the head is
  // the count of the present cycle and the last entry is the boundary.
  int         m_shd[4];
  int         m_act[4];
  int         m_p;
  logic       m_mode;
  int         m_q[$];
  logic [3:0] m_out;
  logic       m_done;

  function automatic void build_period(bit first);
    m_q.delete();
    if (m_mode == 1'b0) begin
      for (int c = 0; c <= m_p; c++) m_q.push_back(c);
    end else if (m_p == 0) begin
      m_q.push_back(0);
    end else begin
      for (int c = (first ? 0 : 1); c <= m_p; c++) m_q.push_back(c);
      for (int c = m_p - 1; c >= 0; c--) m_q.push_back(c);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_shd[i] = 0;
      m_act[i] = 0;
    end
    m_p    = 0;
    m_mode = 1'b0;
    m_out  = 4'b0000;
    m_done = 1'b0;
    build_period(1'b1);
  endfunction

  function automatic void model_edge();
    int cur;
    cur = m_q[0];
    if (!en) begin
      m_out  = 4'b0000;
      m_done = 1'b0;
      m_act  = m_shd;
      m_p    = int'(period);
      m_mode = mode;
      build_period(1'b1);
    end else begin
      for (int i = 0; i < 4; i++) m_out[i] = (cur < m_act[i]);
      if (m_q.size() == 1) begin
        m_done = 1'b1;
        m_act  = m_shd;
        m_p    = int'(period);
        m_mode = mode;
        build_period(1'b0);
      end else begin
        m_done = 1'b0;
        void'(m_q.pop_front());
      end
    end
    if (wr_en) m_shd[wr_ch] = int'(wr_duty);
  endfunction

  // ---------------- checking helpers ----------------
  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // One clock: model advances on the edge, DUT outputs are compared mid-cycle.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    check("out_inv0", {28'd0, out0}, {28'd0, m_out});
    check("out_inv1010", {28'd0, out1}, {28'd0, m_out ^ INV1});
    check("out_3ch", {29'd0, out2}, {29'd0, m_out[2:0]});
    check("period_done", {29'd0, done0, done1, done2}, {29'd0, {3{m_done}}});
  endtask

  task automatic write_duty(input int ch, input int d);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_duty = 8'(d);
    tick();
    wr_en = 1'b0;
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    logic            mode;
    logic [7:0]      p;
    logic [3:0][7:0] d;
    int              plen;
    logic [3:0][7:0] hi;
  } vec_t;

  vec_t tbl[6];

  // Load a scenario while disabled, run past the first period, then count
  // active cycles per channel and period_done pulses over three periods.
  task automatic apply_row(input int r);
    int hi[4];
    int dn;
    en     = 1'b0;
    mode   = tbl[r].mode;
    period = tbl[r].p;
    for (int ch = 0; ch < 4; ch++) write_duty(ch, int'(tbl[r].d[ch]));
    tick();
    en = 1'b1;
    repeat (2 * tbl[r].plen + 4) tick();
    for (int i = 0; i < 4; i++) hi[i] = 0;
    dn = 0;
    repeat (3 * tbl[r].plen) begin
      tick();
      for (int i = 0; i < 4; i++) hi[i] += int'(out0[i]);
      dn += int'(done0);
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("row%0d_ch%0d_active_cycles", r, i), 32'(hi[i]), 32'(3 * int'(tbl[r].hi[i])));
    end
    check($sformatf("row%0d_done_count", r), 32'(dn), 32'd3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int hi1;
    int guard;
    logic [3:0] seen;

    tbl[0] = '{mode: 1'b0, p: 8'd9,   d: {8'd12, 8'd5, 8'd3, 8'd0},    plen: 10,  hi: {8'd10, 8'd5, 8'd3, 8'd0}};
    tbl[1] = '{mode: 1'b1, p: 8'd8,   d: {8'd9, 8'd8, 8'd1, 8'd4},     plen: 16,  hi: {8'd16, 8'd15, 8'd1, 8'd7}};
    tbl[2] = '{mode: 1'b0, p: 8'd0,   d: {8'd0, 8'd5, 8'd0, 8'd1},     plen: 1,   hi: {8'd0, 8'd1, 8'd0, 8'd1}};
    tbl[3] = '{mode: 1'b1, p: 8'd0,   d: {8'd0, 8'd2, 8'd0, 8'd1},     plen: 1,   hi: {8'd0, 8'd1, 8'd0, 8'd1}};
    tbl[4] = '{mode: 1'b1, p: 8'd3,   d: {8'd1, 8'd0, 8'd3, 8'd2},     plen: 6,   hi: {8'd1, 8'd0, 8'd5, 8'd3}};
    tbl[5] = '{mode: 1'b0, p: 8'd255, d: {8'd0, 8'd1, 8'd128, 8'd255}, plen: 256, hi: {8'd0, 8'd1, 8'd128, 8'd255}};

    rst = 1'b1; en = 1'b0; mode = 1'b0; period = 8'd0;
    wr_en = 1'b0; wr_ch = 2'd0; wr_duty = 8'd0;
    model_reset();
    @(negedge clk);
    check("reset_out0", {28'd0, out0}, 32'd0);
    check("reset_out1", {28'd0, out1}, {28'd0, INV1});
    check("reset_done", {31'd0, done0}, 32'd0);
    tick();
    rst = 1'b0;

    // Duty/period/mode scenarios.
    for (int r = 0; r < 6; r++) apply_row(r);

    // Duty write mid-period and on the boundary; period change mid-period.
    en = 1'b0; mode = 1'b0; period = 8'd9;
    write_duty(1, 3);
    tick();
    en = 1'b1;
    guard = 0;
    tick();
    while (!done0 && guard < 40) begin
      tick();
      guard++;
    end
    check("seq3_wait_done", {31'd0, done0}, 32'd1);
    hi1 = 0;
    for (int j = 0; j < 10; j++) begin
      wr_en   = (j == 0) || (j == 9);
      wr_ch   = 2'd1;
      wr_duty = (j == 0) ? 8'd7 : 8'd2;
      tick();
      hi1 += int'(out0[1]);
    end
    wr_en = 1'b0;
    check("seq3_old_duty_holds", 32'(hi1), 32'd3);
    check("seq3_done_p1", {31'd0, done0}, 32'd1);
    hi1 = 0;
    for (int j = 0; j < 10; j++) begin
      if (j == 3) period = 8'd4;
      tick();
      hi1 += int'(out0[1]);
    end
    check("seq3_new_duty", 32'(hi1), 32'd7);
    check("seq3_done_p2", {31'd0, done0}, 32'd1);
    hi1 = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      hi1 += int'(out0[1]);
    end
    check("seq3_boundary_write_and_short_period", 32'(hi1), 32'd2);
    check("seq3_done_p3", {31'd0, done0}, 32'd1);

    // en falling mid-pulse, plus an out-of-range write on the 3-channel instance.
    write_duty(3, 200);
    repeat (12) tick();
    check("seq5_ch3_active", {31'd0, out0[3]}, 32'd1);
    en = 1'b0;
    tick();
    check("seq5_idle_inv", {28'd0, out1}, {28'd0, INV1});
    write_duty(3, 0);
    write_duty(2, 0);
    tick();
    en = 1'b1;
    repeat (8) tick();
    check("seq5_out_of_range_write_ignored", {29'd0, out2}, {29'd0, m_out[2:0]});

    // Asynchronous reset in the middle of an active pulse.
    write_duty(0, 200);
    repeat (10) tick();
    check("seq6_pulse_high", {31'd0, out0[0]}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("seq6_async_out0", {28'd0, out0}, 32'd0);
    check("seq6_async_out1", {28'd0, out1}, {28'd0, INV1});
    model_reset();
    tick();
    rst = 1'b0; en = 1'b1; mode = 1'b0; period = 8'd5;
    seen = 4'b0000;
    repeat (12) begin
      tick();
      seen |= out0;
    end
    check("seq6_duties_cleared", {28'd0, seen}, 32'd0);

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 499) == 0);
      en  = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 15) == 0) mode = 1'($urandom);
      if ($urandom_range(0, 19) == 0) period = 8'($urandom_range(0, 12));
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_ch   = 2'($urandom);
      wr_duty = 8'($urandom_range(0, 14));
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
